// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with valid/ready load handshake and
// stall-capable serial side; back-to-back words stream with no idle gap.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic             SHIFT_EN,
    output logic             SO,
    output logic             SO_VALID,
    output logic             SO_LAST,
    output logic             BUSY
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               shifting_c;
    logic               last_c;
    logic               accept_c;
    logic [WIDTH-1:0]   shifted_c;

    // Status decode and load handshake; ready opens on the final bit so a
    // new word can follow without an idle cycle.
    always_comb begin
        shifting_c = (state_q == S_SHIFT);
        last_c     = shifting_c && (cnt_q == LAST_CNT);
        LOAD_READY = RST_N && ((state_q == S_IDLE) || (last_c && SHIFT_EN));
        accept_c   = LOAD_VALID && LOAD_READY;
    end

    // Shift toward the output end, filling with zero.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_c = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted_c = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: load, shift, or return to idle after the last bit.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept_c) begin
            state_d = S_SHIFT;
            shreg_d = DIN;
            cnt_d   = '0;
        end else if (shifting_c && SHIFT_EN) begin
            shreg_d = shifted_c;
            if (last_c) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // State, data and counter registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Serial outputs are forced low while idle.
    always_comb begin
        BUSY     = shifting_c;
        SO_VALID = shifting_c;
        SO_LAST  = last_c;
        if (!shifting_c) begin
            SO = 1'b0;
        end else if (MSB_FIRST) begin
            SO = shreg_q[WIDTH-1];
        end else begin
            SO = shreg_q[0];
        end
    end

endmodule
